// File: rtl/ipsxb_qsgmii_lane_rst_pkg.sv
// Shared state encodings and default timing constants for the QSGMII lane reset sequencer.
package ipsxb_qsgmii_lane_rst_pkg;

    localparam logic [2:0] TxEncPllRst   = 3'd0;
    localparam logic [2:0] TxEncWaitLock = 3'd1;
    localparam logic [2:0] TxEncPmaRst   = 3'd2;
    localparam logic [2:0] TxEncPcsRst   = 3'd3;
    localparam logic [2:0] TxEncDone     = 3'd4;

    localparam logic [2:0] RxEncIdle      = 3'd0;
    localparam logic [2:0] RxEncPmaRst    = 3'd1;
    localparam logic [2:0] RxEncWaitCdr   = 3'd2;
    localparam logic [2:0] RxEncWaitAlign = 3'd3;
    localparam logic [2:0] RxEncDone      = 3'd4;

    typedef enum logic [2:0] {
        TxPllRst   = TxEncPllRst,
        TxWaitLock = TxEncWaitLock,
        TxPmaRst   = TxEncPmaRst,
        TxPcsRst   = TxEncPcsRst,
        TxDone     = TxEncDone
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle      = RxEncIdle,
        RxPmaRst    = RxEncPmaRst,
        RxWaitCdr   = RxEncWaitCdr,
        RxWaitAlign = RxEncWaitAlign,
        RxDone      = RxEncDone
    } rx_state_e;

    localparam int unsigned DefPllRstCycles    = 64;
    localparam int unsigned DefPmaRstCycles    = 32;
    localparam int unsigned DefLockTimeout     = 65535;
    localparam int unsigned DefCdrStableCycles = 256;
    localparam int unsigned DefAlignTimeout    = 65535;
    localparam int unsigned DefCntW            = 16;

endpackage

// File: rtl/ipsxb_qsgmii_sync2_v1_0.sv
// Two-flop synchronizer for a single asynchronous status bit; resets to 0.
module ipsxb_qsgmii_sync2_v1_0 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ipsxb_qsgmii_hsst_lane_rst_seq_v1_0.sv
// Per-lane HSST bring-up: sequences PLL, TX and RX resets and reports tx/rx lane done,
// re-sequencing on PLL lock loss, signal loss, CDR unlock or alignment timeout.
module ipsxb_qsgmii_hsst_lane_rst_seq_v1_0
    import ipsxb_qsgmii_lane_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES    = DefPllRstCycles,
    parameter int unsigned PMA_RST_CYCLES    = DefPmaRstCycles,
    parameter int unsigned LOCK_TIMEOUT      = DefLockTimeout,
    parameter int unsigned CDR_STABLE_CYCLES = DefCdrStableCycles,
    parameter int unsigned ALIGN_TIMEOUT     = DefAlignTimeout,
    parameter int unsigned CNT_W             = DefCntW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       rx_sigdet,
    input  logic       rx_cdr_lock,
    input  logic       rx_align_done,
    output logic       pll_rst,
    output logic       tx_pma_rst,
    output logic       tx_pcs_rst,
    output logic       rx_pma_rst,
    output logic       rx_pcs_rst,
    output logic       tx_lane_done,
    output logic       rx_lane_done,
    output logic [2:0] o_tx_state,
    output logic [2:0] o_rx_state
);

    // Each timed state is left on the edge where its counter holds duration-1.
    localparam logic [CNT_W-1:0] PllLast   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] PmaLast   = CNT_W'(PMA_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LockLast  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CdrLast   = CNT_W'(CDR_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] AlignLast = CNT_W'(ALIGN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    logic pll_lock_s, sigdet_s, cdr_lock_s, align_done_s;

    ipsxb_qsgmii_sync2_v1_0 u_sync_pll_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (pll_lock_s)
    );

    ipsxb_qsgmii_sync2_v1_0 u_sync_sigdet (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_sigdet),
        .q     (sigdet_s)
    );

    ipsxb_qsgmii_sync2_v1_0 u_sync_cdr_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_cdr_lock),
        .q     (cdr_lock_s)
    );

    ipsxb_qsgmii_sync2_v1_0 u_sync_align_done (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_align_done),
        .q     (align_done_s)
    );

    tx_state_e        tx_state_q, tx_state_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             tx_done_d;

    logic pll_rst_q, tx_pma_rst_q, tx_pcs_rst_q, rx_pma_rst_q, rx_pcs_rst_q;
    logic tx_lane_done_q, rx_lane_done_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q == CntMax) ? tx_cnt_q : tx_cnt_q + CntOne;
        unique case (tx_state_q)
            TxPllRst: begin
                if (tx_cnt_q >= PllLast) tx_state_d = TxWaitLock;
            end
            TxWaitLock: begin
                if (pll_lock_s)                tx_state_d = TxPmaRst;
                else if (tx_cnt_q >= LockLast) tx_state_d = TxPllRst;
            end
            TxPmaRst: begin
                if (!pll_lock_s)              tx_state_d = TxPllRst;
                else if (tx_cnt_q >= PmaLast) tx_state_d = TxPcsRst;
            end
            TxPcsRst: begin
                tx_state_d = pll_lock_s ? TxDone : TxPllRst;
            end
            TxDone: begin
                if (!pll_lock_s) tx_state_d = TxPllRst;
            end
            default: tx_state_d = TxPllRst;
        endcase
        if (tx_state_d != tx_state_q) tx_cnt_d = '0;
    end

    // RX follows the TX next state so a TX drop pulls RX down on the same edge.
    assign tx_done_d = (tx_state_d == TxDone);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = (rx_cnt_q == CntMax) ? rx_cnt_q : rx_cnt_q + CntOne;
        if (!tx_done_d) begin
            rx_state_d = RxIdle;
        end else if (rx_state_q != RxIdle && !sigdet_s) begin
            rx_state_d = RxIdle;
        end else if ((rx_state_q == RxWaitAlign || rx_state_q == RxDone) && !cdr_lock_s) begin
            rx_state_d = RxPmaRst;
        end else begin
            unique case (rx_state_q)
                RxIdle: begin
                    if (tx_lane_done_q && sigdet_s) rx_state_d = RxPmaRst;
                end
                RxPmaRst: begin
                    if (rx_cnt_q >= PmaLast) rx_state_d = RxWaitCdr;
                end
                RxWaitCdr: begin
                    if (!cdr_lock_s)              rx_cnt_d   = '0;
                    else if (rx_cnt_q >= CdrLast) rx_state_d = RxWaitAlign;
                end
                RxWaitAlign: begin
                    if (align_done_s)               rx_state_d = RxDone;
                    else if (rx_cnt_q >= AlignLast) rx_state_d = RxPmaRst;
                end
                RxDone: ;
                default: rx_state_d = RxIdle;
            endcase
        end
        if (rx_state_d != rx_state_q) rx_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q     <= TxPllRst;
            rx_state_q     <= RxIdle;
            tx_cnt_q       <= '0;
            rx_cnt_q       <= '0;
            pll_rst_q      <= 1'b1;
            tx_pma_rst_q   <= 1'b1;
            tx_pcs_rst_q   <= 1'b1;
            rx_pma_rst_q   <= 1'b1;
            rx_pcs_rst_q   <= 1'b1;
            tx_lane_done_q <= 1'b0;
            rx_lane_done_q <= 1'b0;
        end else begin
            tx_state_q     <= tx_state_d;
            rx_state_q     <= rx_state_d;
            tx_cnt_q       <= tx_cnt_d;
            rx_cnt_q       <= rx_cnt_d;
            pll_rst_q      <= (tx_state_d == TxPllRst);
            tx_pma_rst_q   <= (tx_state_d inside {TxPllRst, TxWaitLock, TxPmaRst});
            tx_pcs_rst_q   <= (tx_state_d != TxDone);
            rx_pma_rst_q   <= (rx_state_d inside {RxIdle, RxPmaRst});
            rx_pcs_rst_q   <= (rx_state_d inside {RxIdle, RxPmaRst, RxWaitCdr});
            tx_lane_done_q <= tx_done_d;
            rx_lane_done_q <= (rx_state_d == RxDone);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign tx_pma_rst   = tx_pma_rst_q;
    assign tx_pcs_rst   = tx_pcs_rst_q;
    assign rx_pma_rst   = rx_pma_rst_q;
    assign rx_pcs_rst   = rx_pcs_rst_q;
    assign tx_lane_done = tx_lane_done_q;
    assign rx_lane_done = rx_lane_done_q;
    assign o_tx_state   = tx_state_q;
    assign o_rx_state   = rx_state_q;

endmodule

// File: tb/tb_ipsxb_qsgmii_hsst_lane_rst_seq_v1_0.sv
// Bench for the lane reset sequencer: expected output transitions are queued by the stimulus
// with their cycle numbers and matched by a monitor whenever the output vector changes.
module tb_ipsxb_qsgmii_hsst_lane_rst_seq_v1_0;

    // Scaled-down timing so timeouts fit in a short run.
    localparam int unsigned PLL_C   = 8;
    localparam int unsigned PMA_C   = 4;
    localparam int unsigned LOCK_TO = 40;
    localparam int unsigned CDR_C   = 16;
    localparam int unsigned ALIGN_T = 30;

    // {pll_rst, tx_pma_rst, tx_pcs_rst, rx_pma_rst, rx_pcs_rst, tx_lane_done, rx_lane_done}
    localparam logic [6:0] RST_VEC = 7'b1111100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock, rx_sigdet, rx_cdr_lock, rx_align_done;
    logic       pll_rst, tx_pma_rst, tx_pcs_rst, rx_pma_rst, rx_pcs_rst;
    logic       tx_lane_done, rx_lane_done;
    logic [2:0] o_tx_state, o_rx_state;
    logic [6:0] out_vec;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int unsigned cyc;
        logic [6:0]  vec;
    } exp_t;
    exp_t exp_q[$];

    ipsxb_qsgmii_hsst_lane_rst_seq_v1_0 #(
        .PLL_RST_CYCLES    (PLL_C),
        .PMA_RST_CYCLES    (PMA_C),
        .LOCK_TIMEOUT      (LOCK_TO),
        .CDR_STABLE_CYCLES (CDR_C),
        .ALIGN_TIMEOUT     (ALIGN_T),
        .CNT_W             (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .rx_sigdet     (rx_sigdet),
        .rx_cdr_lock   (rx_cdr_lock),
        .rx_align_done (rx_align_done),
        .pll_rst       (pll_rst),
        .tx_pma_rst    (tx_pma_rst),
        .tx_pcs_rst    (tx_pcs_rst),
        .rx_pma_rst    (rx_pma_rst),
        .rx_pcs_rst    (rx_pcs_rst),
        .tx_lane_done  (tx_lane_done),
        .rx_lane_done  (rx_lane_done),
        .o_tx_state    (o_tx_state),
        .o_rx_state    (o_rx_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign out_vec = {pll_rst, tx_pma_rst, tx_pcs_rst, rx_pma_rst, rx_pcs_rst,
                      tx_lane_done, rx_lane_done};

    task automatic expect_at(input int unsigned c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every change of the output vector must match the next queued expectation.
    initial begin : monitor
        logic [6:0] prev;
        logic [6:0] vec;
        exp_t       e;
        prev = RST_VEC;
        forever begin
            @(negedge clk);
            #1;
            vec = out_vec;
            total++;
            if (rx_lane_done && !tx_lane_done) begin
                bad++;
                $display("FAIL done_invariant: rx_lane_done=1 with tx_lane_done=0 (cycle %0d)", cyc);
            end
            if (vec !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, none expected", vec, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== vec) begin
                        bad++;
                        $display("FAIL transition: got %b at cycle %0d, expected %b at cycle %0d",
                                 vec, cyc, e.vec, e.cyc);
                    end
                end
                prev = vec;
            end
        end
    end

    initial begin : stimulus
        int unsigned c0, c1, c2, c3, c4, c5;
        rst_n         = 1'b0;
        pll_lock      = 1'b0;
        rx_sigdet     = 1'b0;
        rx_cdr_lock   = 1'b0;
        rx_align_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 32'(out_vec), 32'(RST_VEC));
        chk("reset_tx_state", 32'(o_tx_state), 32'd0);
        chk("reset_rx_state", 32'(o_rx_state), 32'd0);

        // No lock: pll_rst re-pulses after every lock timeout.
        @(negedge clk);
        c0 = cyc;
        rst_n       = 1'b1;
        rx_sigdet   = 1'b1;
        rx_cdr_lock = 1'b1;
        expect_at(c0 + 8,   7'b0111100);
        expect_at(c0 + 48,  RST_VEC);
        expect_at(c0 + 56,  7'b0111100);
        expect_at(c0 + 96,  RST_VEC);
        expect_at(c0 + 104, 7'b0111100);

        // Baseline bring-up.
        wait_until(c0 + 110);
        c1 = cyc;
        pll_lock = 1'b1;
        expect_at(c1 + 7,  7'b0011100);
        expect_at(c1 + 8,  7'b0001110);
        expect_at(c1 + 13, 7'b0000110);
        expect_at(c1 + 29, 7'b0000010);
        wait_until(c1 + 39);
        rx_align_done = 1'b1;
        expect_at(c1 + 42, 7'b0000011);

        // Lock lost for 5 cycles in DONE: everything drops and re-sequences.
        wait_until(c1 + 60);
        c2 = cyc;
        pll_lock = 1'b0;
        expect_at(c2 + 3,  RST_VEC);
        expect_at(c2 + 11, 7'b0111100);
        expect_at(c2 + 16, 7'b0011100);
        expect_at(c2 + 17, 7'b0001110);
        expect_at(c2 + 22, 7'b0000110);
        expect_at(c2 + 38, 7'b0000010);
        expect_at(c2 + 39, 7'b0000011);
        wait_until(c2 + 5);
        pll_lock = 1'b1;

        // Signal loss back to RX_IDLE, then a CDR glitch at stable count 10.
        wait_until(c2 + 50);
        c3 = cyc;
        rx_align_done = 1'b0;
        rx_sigdet     = 1'b0;
        expect_at(c3 + 3,  7'b0001110);
        expect_at(c3 + 12, 7'b0000110);
        wait_until(c3 + 5);
        rx_sigdet = 1'b1;
        wait_until(c3 + 20);
        rx_cdr_lock = 1'b0;
        wait_until(c3 + 21);
        rx_cdr_lock = 1'b1;
        expect_at(c3 + 39, 7'b0000010);
        // Alignment never arrives: timeout back to RX_PMA_RST, TX stays done.
        expect_at(c3 + 69, 7'b0001110);
        expect_at(c3 + 73, 7'b0000110);

        // Async reset in RX_WAIT_CDR, then a clean restart.
        wait_until(c3 + 80);
        c4 = cyc;
        rst_n = 1'b0;
        expect_at(c4, RST_VEC);
        #1;
        chk("async_rst_tx_state", 32'(o_tx_state), 32'd0);
        chk("async_rst_rx_state", 32'(o_rx_state), 32'd0);
        wait_until(c4 + 3);
        c5 = cyc;
        rst_n = 1'b1;
        expect_at(c5 + 8,  7'b0111100);
        expect_at(c5 + 13, 7'b0011100);
        expect_at(c5 + 14, 7'b0001110);
        expect_at(c5 + 19, 7'b0000110);
        expect_at(c5 + 35, 7'b0000010);
        wait_until(c5 + 36);
        rx_align_done = 1'b1;
        expect_at(c5 + 39, 7'b0000011);

        wait_until(c5 + 50);
        #2;
        chk("final_tx_state", 32'(o_tx_state), 32'd4);
        chk("final_rx_state", 32'(o_rx_state), 32'd4);
        chk("final_rx_done", 32'(rx_lane_done), 32'd1);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_transition: got no change, expected %b at cycle %0d",
                     e.vec, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
